alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issues one instruction every three cycles to an external 8-bit ALU, with a 4x8 register file and Z/C flags.
// Optional build macro ALU_SEQ_COND_EN: instruction bit 8 makes execution conditional on flag_z.
module alu_sequencer #(
  parameter int NREGS = 4,
  parameter int IW    = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [IW-1:0] instr_data,
  output logic [3:0]    alu_opcode,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  input  logic [7:0]    alu_out,
  input  logic          alu_zero,
  input  logic          alu_carry,
  output logic          done,
  output logic [7:0]    done_data,
  output logic          done_skip,
  output logic          flag_z,
  output logic          flag_c,
  output logic          err,
  input  logic [1:0]    dbg_addr,
  output logic [7:0]    dbg_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [3:0] OP_LOADI = 4'hC;

  logic [1:0]       state_reg, state_next;
  logic [3:0]       op_reg;
  logic [1:0]       rd_reg, ra_reg, rb_reg;
  logic             use_imm_reg;
  logic [7:0]       imm_reg;
  logic             skip_reg, skip_next;
  logic [7:0]       result_reg, result_next;
  logic             res_z_reg, res_c_reg;
  logic             flag_z_reg, flag_c_reg, err_reg;
  logic [7:0]       regfile [NREGS];
  logic [NREGS-1:0] rf_we;
  logic             accept, is_alu_op, is_loadi, is_illegal, exec_active, wb_active;

  assign instr_ready = (state_reg == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign is_alu_op   = (op_reg != 4'h0) && (op_reg <= 4'hB);
  assign is_loadi    = (op_reg == OP_LOADI);
  assign is_illegal  = (op_reg > OP_LOADI);
  // A squashed instruction still walks EXEC/WB but must look like a bubble.
  assign exec_active = (state_reg == EXEC) && !skip_reg;
  assign wb_active   = (state_reg == WB) && !skip_reg;

`ifdef ALU_SEQ_COND_EN
  assign skip_next = instr_data[8] && !flag_z_reg;
  assign done_skip = (state_reg == WB) && skip_reg;
`else
  logic unused_cond;
  assign unused_cond = instr_data[8];
  assign skip_next   = 1'b0;
  assign done_skip   = 1'b0;
`endif

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = accept ? EXEC : IDLE;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_opcode = 4'h0;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    if (exec_active) begin
      if (!is_loadi) alu_opcode = op_reg;
      alu_a = regfile[ra_reg];
      alu_b = use_imm_reg ? imm_reg : regfile[rb_reg];
    end
  end

  always_comb begin
    result_next = 8'h00;
    if (!skip_reg) begin
      if (is_alu_op)     result_next = alu_out;
      else if (is_loadi) result_next = imm_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_rf_we
      assign rf_we[gi] = wb_active && (is_alu_op || is_loadi) && (rd_reg == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regfile[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (rf_we[i]) regfile[i] <= result_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      op_reg      <= 4'h0;
      rd_reg      <= 2'd0;
      ra_reg      <= 2'd0;
      rb_reg      <= 2'd0;
      use_imm_reg <= 1'b0;
      imm_reg     <= 8'h00;
      skip_reg    <= 1'b0;
      result_reg  <= 8'h00;
      res_z_reg   <= 1'b0;
      res_c_reg   <= 1'b0;
      flag_z_reg  <= 1'b0;
      flag_c_reg  <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg      <= instr_data[19:16];
        rd_reg      <= instr_data[15:14];
        ra_reg      <= instr_data[13:12];
        rb_reg      <= instr_data[11:10];
        use_imm_reg <= instr_data[9];
        imm_reg     <= instr_data[7:0];
        skip_reg    <= skip_next;
      end
      if (state_reg == EXEC) begin
        result_reg <= result_next;
        res_z_reg  <= alu_zero;
        res_c_reg  <= alu_carry;
      end
      if (wb_active) begin
        if (is_alu_op) begin
          flag_z_reg <= res_z_reg;
          flag_c_reg <= res_c_reg;
        end else if (is_loadi) begin
          flag_z_reg <= (imm_reg == 8'h00);
        end
        if (is_illegal) err_reg <= 1'b1;
      end
    end
  end

  assign done      = (state_reg == WB);
  assign done_data = done ? result_reg : 8'h00;
  assign flag_z    = flag_z_reg;
  assign flag_c    = flag_c_reg;
  assign err       = err_reg;
  assign dbg_data  = regfile[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: models the external ALU, runs a directed table, back-to-back,
// reset-abort and conditional sequences, then random instructions against a reference model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [19:0] instr_data;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_zero, alu_carry;
  logic        done, done_skip, flag_z, flag_c, err;
  logic [7:0]  done_data;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(4), .IW(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .done(done), .done_data(done_data), .done_skip(done_skip),
    .flag_z(flag_z), .flag_c(flag_c), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

`ifdef ALU_SEQ_COND_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  typedef struct {
    logic [19:0] ins;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  data;
    logic        skip;
    logic        z;
    logic        c;
    logic        err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Returns {carry, zero, result}
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] w;
    w = 9'h000;
    case (op)
      4'h1: w = {1'b0, a} + {1'b0, b};
      4'h2: w = {1'b0, a} - {1'b0, b};
      4'h3: w = {1'b0, a & b};
      4'h4: w = {1'b0, a | b};
      4'h5: w = {1'b0, a ^ b};
      4'h6: w = {1'b0, ~a};
      4'h7: w = {a, 1'b0};
      4'h8: w = {a[0], 1'b0, a[7:1]};
      4'h9: w = {1'b0, a} + 9'd1;
      4'hA: w = {1'b0, a} - 9'd1;
      4'hB: w = {1'b0, b};
      default: w = 9'h000;
    endcase
    return {w[8], (w[7:0] == 8'h00), w[7:0]};
  endfunction

  always_comb {alu_carry, alu_zero, alu_out} = alu_fn(alu_opcode, alu_a, alu_b);

  logic [7:0] ref_rf [4];
  logic       ref_z, ref_c, ref_err;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    ref_z = 1'b0;
    ref_c = 1'b0;
    ref_err = 1'b0;
  endfunction

  function automatic logic [19:0] enc(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                                      input logic [1:0] rb, input logic ui, input logic cond, input logic [7:0] imm);
    return {op, rd, ra, rb, ui, cond, imm};
  endfunction

  // Architectural effect of one instruction, applied to the model state.
  function automatic vec_t model_step(input logic [19:0] ins);
    vec_t e;
    logic [3:0] op;
    logic [7:0] imm;
    logic [9:0] r;
    op = ins[19:16];
    imm = ins[7:0];
    e.ins = ins;
    e.skip = COND_EN && ins[8] && !ref_z;
    e.op = 4'h0;
    e.a = 8'h00;
    e.b = 8'h00;
    e.data = 8'h00;
    if (!e.skip) begin
      e.a = ref_rf[ins[13:12]];
      e.b = ins[9] ? imm : ref_rf[ins[11:10]];
      e.op = (op == 4'hC) ? 4'h0 : op;
      if (op >= 4'h1 && op <= 4'hB) begin
        r = alu_fn(op, e.a, e.b);
        e.data = r[7:0];
        ref_rf[ins[15:14]] = r[7:0];
        ref_z = r[8];
        ref_c = r[9];
      end else if (op == 4'hC) begin
        e.data = imm;
        ref_rf[ins[15:14]] = imm;
        ref_z = (imm == 8'h00);
      end else if (op >= 4'hD) begin
        ref_err = 1'b1;
      end
    end
    e.z = ref_z;
    e.c = ref_c;
    e.err = ref_err;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [19:0] ins, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] data, input logic skip, input logic z, input logic c, input logic e);
    vec_t v;
    v.ins = ins; v.op = op; v.a = a; v.b = b; v.data = data;
    v.skip = skip; v.z = z; v.c = c; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      check($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(ref_rf[i]));
    end
  endtask

  // Entered and left at #1 after a rising edge with the DUT idle.
  task automatic issue(input vec_t e, input int txn);
    check("ready_idle", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_data = e.ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_data = 20'($urandom);
    check("ready_exec", 32'(instr_ready), 32'd0);
    check("done_exec", 32'(done), 32'd0);
    check("alu_opcode", 32'(alu_opcode), 32'(e.op));
    check("alu_a", 32'(alu_a), 32'(e.a));
    check("alu_b", 32'(alu_b), 32'(e.b));
    @(posedge clk); #1;
    check("done_wb", 32'(done), 32'd1);
    check("done_data", 32'(done_data), 32'(e.data));
    check("done_skip", 32'(done_skip), 32'(e.skip));
    check("ready_wb", 32'(instr_ready), 32'd0);
    check("alu_opcode_wb", 32'(alu_opcode), 32'd0);
    @(posedge clk); #1;
    check("done_after", 32'(done), 32'd0);
    check("ready_after", 32'(instr_ready), 32'd1);
    check("flag_z", 32'(flag_z), 32'(e.z));
    check("flag_c", 32'(flag_c), 32'(e.c));
    check("err", 32'(err), 32'(e.err));
    check_regs("reg");
    $display("txn %0d instr=%h done_data=%h skip=%0d z=%0d c=%0d err=%0d",
             txn, e.ins, done_data, e.skip, flag_z, flag_c, err);
  endtask

  vec_t tab [8];
  vec_t bq [3];
  vec_t ev;
  int   acc_cyc [3];
  int   acc_n, done_n;
  logic acc;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    instr_valid = 1'b0;
    instr_data = 20'h0;
    dbg_addr = 2'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_data", 32'(done_data), 32'd0);
    check("rst_done_skip", 32'(done_skip), 32'd0);
    check("rst_flags", 32'({flag_z, flag_c, err}), 32'd0);
    check("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    check_regs("rst");

    tab[0] = mkv(enc(4'hC, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 8'h0F), 4'h0, 8'h00, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[1] = mkv(enc(4'hC, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 8'hF1), 4'h0, 8'h00, 8'h00, 8'hF1, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[2] = mkv(enc(4'h1, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 8'h00), 4'h1, 8'h0F, 8'hF1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tab[3] = mkv(enc(4'h1, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 8'h01), 4'h1, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    tab[4] = mkv(enc(4'hE, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0, 8'h00), 4'hE, 8'h0F, 8'hF1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tab[5] = mkv(enc(4'h0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 8'h00), 4'h0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    tab[6] = mkv(enc(4'h2, 2'd2, 2'd2, 2'd1, 1'b0, 1'b0, 8'h00), 4'h2, 8'hF1, 8'h0F, 8'hE2, 1'b0, 1'b0, 1'b0, 1'b1);
    tab[7] = mkv(enc(4'hC, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00), 4'h0, 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      ev = model_step(tab[i].ins);
      issue(tab[i], i);
    end

    // Three instructions with instr_valid held high throughout.
    bq[0] = model_step(enc(4'h1, 2'd1, 2'd3, 2'd0, 1'b1, 1'b0, 8'h05));
    bq[1] = model_step(enc(4'hC, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 8'h80));
    bq[2] = model_step(enc(4'h5, 2'd0, 2'd1, 2'd2, 1'b0, 1'b0, 8'h00));
    acc_n = 0;
    done_n = 0;
    for (int k = 0; k < 3; k++) acc_cyc[k] = 0;
    instr_valid = 1'b1;
    instr_data = bq[0].ins;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 9) check($sformatf("b2b_ready_c%0d", cyc), 32'(instr_ready), 32'(cyc % 3 == 0));
      if (done) begin
        if (done_n < 3) begin
          check("b2b_done_cycle", 32'(cyc), 32'(acc_cyc[done_n] + 2));
          check("b2b_done_data", 32'(done_data), 32'(bq[done_n].data));
        end
        done_n++;
      end
      acc = instr_ready && instr_valid;
      @(posedge clk); #1;
      if (acc) begin
        if (acc_n < 3) acc_cyc[acc_n] = cyc;
        acc_n++;
        if (acc_n < 3) instr_data = bq[acc_n].ins;
        else instr_valid = 1'b0;
      end
    end
    check("b2b_accepts", 32'(acc_n), 32'd3);
    check("b2b_dones", 32'(done_n), 32'd3);
    for (int k = 0; k < 3; k++) check($sformatf("b2b_accept_cycle%0d", k), 32'(acc_cyc[k]), 32'(3 * k));
    check_regs("b2b");
    $display("txn b2b accepts=%0d dones=%0d", acc_n, done_n);

    // Reset during EXEC aborts the LOADI.
    instr_valid = 1'b1;
    instr_data = enc(4'hC, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 8'hAA);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("rexec_in_exec", 32'(instr_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rexec_ready", 32'(instr_ready), 32'd1);
    check("rexec_done", 32'(done), 32'd0);
    check("rexec_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    model_reset();
    @(posedge clk); #1;
    #2 reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rexec_no_done", 32'(done), 32'd0);
    end
    check("rexec_flags", 32'({flag_z, flag_c, err}), 32'd0);
    check_regs("rexec");
    $display("txn reset_in_exec done=%0d err=%0d", done, err);

    // Reset during WB: the done pulse drops and nothing is written.
    instr_valid = 1'b1;
    instr_data = enc(4'hC, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 8'h33);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("rwb_in_wb", 32'(done), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rwb_done", 32'(done), 32'd0);
    check("rwb_done_data", 32'(done_data), 32'd0);
    @(posedge clk); #1;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rwb_flags", 32'({flag_z, flag_c, err}), 32'd0);
    check_regs("rwb");
    $display("txn reset_in_wb done=%0d", done);

    // Conditional LOADI with flag_z clear, then set.
    issue(model_step(enc(4'hC, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 8'h55)), 100);
    issue(model_step(enc(4'hC, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00)), 101);
    issue(model_step(enc(4'hC, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 8'h55)), 102);

    for (int n = 0; n < 40; n++) begin
      issue(model_step(20'($urandom)), 200 + n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
